// File: rtl/x_mem_pkg.sv
// x_mem_pkg: shared types and RAM geometry for the capture sequencer and its RAM.
package x_mem_pkg;
    localparam int MEM_AW = 8;
    localparam int MEM_DW = 16;
    localparam int MEM_WORDS = 256;
    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_RD_REQ,
        S_RD_WAIT,
        S_SEND_LO,
        S_SEND_HI
    } state_e;
    typedef enum logic {
        BYTE_LO,
        BYTE_HI
    } byte_sel_e;
endpackage

// File: rtl/x_mem.sv
// x_mem: 256 x 16 block RAM, one write port, registered read with 1-cycle latency.
module x_mem
    import x_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_wen,
    input  logic [MEM_AW-1:0] i_waddr,
    input  logic [MEM_DW-1:0] i_wdata,
    input  logic              i_ren,
    input  logic [MEM_AW-1:0] i_raddr,
    output logic [MEM_DW-1:0] o_rdata
);
    logic [MEM_DW-1:0] mem [MEM_WORDS];
    always_ff @(posedge i_clk) begin
        if (i_wen) mem[i_waddr] <= i_wdata;
        if (i_ren) o_rdata <= mem[i_raddr];
`ifdef SIM
        else o_rdata <= 'x;
`endif
    end
endmodule

// File: rtl/x_mem_capture_ctrl.sv
// x_mem_capture_ctrl: captures a triggered burst of samples into x_mem and
// drains it little-endian as a byte stream over a valid/ready handshake.
module x_mem_capture_ctrl
    import x_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW = MEM_AW
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_arm,
    input  logic        i_abort,
    input  logic        i_trig,
    input  logic        i_sample_valid,
    input  logic [15:0] i_sample,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready,
    output logic        o_busy,
    output logic        o_done
);
    localparam logic [AW:0] LAST_W = (AW+1)'(DEPTH - 1);
    localparam logic [AW-1:0] LAST_R = AW'(DEPTH - 1);
    state_e state_q, state_d;
    byte_sel_e sel;
    logic [AW:0] cnt_q;
    logic [AW-1:0] raddr_q;
    logic [MEM_DW-1:0] hold_q, mem_rdata;
    logic mem_wen, mem_ren, last_w, last_r, fire_hi, done_q;
    assign last_w = cnt_q == LAST_W;
    assign last_r = raddr_q == LAST_R;
    assign fire_hi = state_q == S_SEND_HI && i_tx_ready;
    assign mem_wen = (state_q == S_CAPTURE || (state_q == S_ARMED && i_trig)) && i_sample_valid;
    assign mem_ren = state_q == S_RD_REQ;
    assign sel = state_q == S_SEND_HI ? BYTE_HI : BYTE_LO;
    assign o_tx_valid = state_q == S_SEND_LO || state_q == S_SEND_HI;
    assign o_tx_data = !o_tx_valid ? 8'h00 : sel == BYTE_HI ? hold_q[15:8] : hold_q[7:0];
    assign o_busy = state_q != S_IDLE;
    assign o_done = done_q;
    x_mem u_mem (
        .i_clk  (i_clk),
        .i_wen  (mem_wen),
        .i_waddr(cnt_q[AW-1:0]),
        .i_wdata(i_sample),
        .i_ren  (mem_ren),
        .i_raddr(raddr_q),
        .o_rdata(mem_rdata)
    );
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = i_arm ? S_ARMED : S_IDLE;
            S_ARMED:   state_d = !i_trig ? S_ARMED : (i_sample_valid && last_w) ? S_RD_REQ : S_CAPTURE;
            S_CAPTURE: state_d = (i_sample_valid && last_w) ? S_RD_REQ : S_CAPTURE;
            S_RD_REQ:  state_d = S_RD_WAIT;
            S_RD_WAIT: state_d = S_SEND_LO;
            S_SEND_LO: state_d = i_tx_ready ? S_SEND_HI : S_SEND_LO;
            S_SEND_HI: state_d = !i_tx_ready ? S_SEND_HI : last_r ? S_IDLE : S_RD_REQ;
            default:   state_d = S_IDLE;
        endcase
        if (i_abort) state_d = S_IDLE;
    end
    // cnt_q is one bit wider than the address so a full 256-word burst ends without wrapping
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
            raddr_q <= '0;
            hold_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fire_hi && last_r && !i_abort;
            if (i_abort || (state_q == S_IDLE && i_arm)) begin
                cnt_q <= '0;
                raddr_q <= '0;
            end else begin
                if (mem_wen) cnt_q <= cnt_q + 1'b1;
                if (fire_hi && !last_r) raddr_q <= raddr_q + 1'b1;
                if (state_q == S_RD_WAIT) hold_q <= mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_x_mem_capture_ctrl.sv
// tb_x_mem_capture_ctrl: directed scenarios against a 4-deep and a 256-deep instance sharing inputs.
module tb_x_mem_capture_ctrl;
    logic clk = 1'b0, rst = 1'b1, arm = 1'b0, abort = 1'b0, trig = 1'b0, sv = 1'b0, tx_ready = 1'b0;
    logic [15:0] sample = '0;
    logic v4, busy4, done4, v256, busy256, done256;
    logic [7:0] d4, d256;
    int total = 0, bad = 0;
    logic [7:0] q4[$], q256[$];
    int done4_cnt = 0, done256_cnt = 0, wr256 = 0, unstable = 0, bd_err = 0;
    logic prev_stall4 = 1'b0, prev_busy4 = 1'b0;
    logic [7:0] prev_d4 = '0;
    logic [7:0] exp_a[8] = '{8'h34, 8'h12, 8'hCD, 8'hAB, 8'h01, 8'h00, 8'hFF, 8'hFF};
    logic [7:0] exp_b[8] = '{8'hA5, 8'h5A, 8'h0F, 8'h0F, 8'hC3, 8'hC3, 8'h81, 8'h7E};
    logic [7:0] exp_c[6] = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h44, 8'h33};

    x_mem_capture_ctrl #(.DEPTH(4)) u_dut4 (
        .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_abort(abort), .i_trig(trig),
        .i_sample_valid(sv), .i_sample(sample), .o_tx_valid(v4), .o_tx_data(d4),
        .i_tx_ready(tx_ready), .o_busy(busy4), .o_done(done4)
    );
    x_mem_capture_ctrl #(.DEPTH(256)) u_dut256 (
        .i_clk(clk), .i_rst(rst), .i_arm(arm), .i_abort(abort), .i_trig(trig),
        .i_sample_valid(sv), .i_sample(sample), .o_tx_valid(v256), .o_tx_data(d256),
        .i_tx_ready(tx_ready), .o_busy(busy256), .o_done(done256)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (v4 && tx_ready) q4.push_back(d4);
        if (v4 && prev_stall4 && d4 !== prev_d4) unstable++;
        prev_stall4 = v4 && !tx_ready;
        prev_d4 = d4;
        if (done4) done4_cnt++;
        if (done4 && (busy4 || !prev_busy4)) bd_err++;
        prev_busy4 = busy4;
        if (v256 && tx_ready) q256.push_back(d256);
        if (done256) done256_cnt++;
        if (u_dut256.mem_wen) wr256++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clean();
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    task automatic burst4(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2, input logic [15:0] w3);
        arm = 1'b1;
        step();
        arm = 1'b0;
        trig = 1'b1; sv = 1'b1; sample = w0;
        step();
        trig = 1'b0; sample = w1;
        step();
        sample = w2;
        step();
        sample = w3;
        step();
        sv = 1'b0;
    endtask

    task automatic wait_done4(input int budget, input bit rnd);
        int start = done4_cnt;
        int n = 0;
        while (done4_cnt == start && n < budget) begin
            tx_ready = rnd ? ($urandom_range(0, 99) < 30) : 1'b1;
            step();
            n++;
        end
        total++;
        if (done4_cnt == start) begin
            bad++;
            $display("FAIL drain_timeout: o_done count=%0d required>%0d", done4_cnt, start);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (v4 !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", v4); end
        total++; if (d4 !== 8'h00) begin bad++; $display("FAIL rst_data: got %h want 00", d4); end
        total++; if (busy4 !== 1'b0 || busy256 !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b/%b want 0/0", busy4, busy256); end
        total++; if (done4 !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done4); end
        total++; if (u_dut4.mem_wen !== 1'b0 || u_dut4.mem_ren !== 1'b0) begin bad++; $display("FAIL rst_ram: wen=%b ren=%b want 0/0", u_dut4.mem_wen, u_dut4.mem_ren); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        clean();
        q4.delete(); done4_cnt = 0; bd_err = 0; tx_ready = 1'b1;
        burst4(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
        wait_done4(100, 1'b0);
        repeat (3) step();
        total++; if (q4.size() != 8) begin bad++; $display("FAIL basic_count: got %0d want 8", q4.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = i < q4.size() ? q4[i] : 8'hxx;
            total++; if (got !== exp_a[i]) begin bad++; $display("FAIL basic_byte%0d: got %h want %h", i, got, exp_a[i]); end
        end
        total++; if (done4_cnt != 1) begin bad++; $display("FAIL basic_done_pulses: got %0d want 1", done4_cnt); end
        total++; if (bd_err != 0) begin bad++; $display("FAIL basic_busy_done_align: got %0d errors want 0", bd_err); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL basic_idle: busy got %b want 0", busy4); end
    endtask

    task automatic test_backpressure();
        clean();
        q4.delete(); done4_cnt = 0; unstable = 0;
        burst4(16'h1234, 16'hABCD, 16'h0001, 16'hFFFF);
        wait_done4(400, 1'b1);
        tx_ready = 1'b1;
        repeat (3) step();
        total++; if (q4.size() != 8) begin bad++; $display("FAIL bp_count: got %0d want 8", q4.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = i < q4.size() ? q4[i] : 8'hxx;
            total++; if (got !== exp_a[i]) begin bad++; $display("FAIL bp_byte%0d: got %h want %h", i, got, exp_a[i]); end
        end
        total++; if (unstable != 0) begin bad++; $display("FAIL bp_stable: got %0d changes while stalled want 0", unstable); end
        total++; if (done4_cnt != 1) begin bad++; $display("FAIL bp_done_pulses: got %0d want 1", done4_cnt); end
    endtask

    task automatic test_gapped();
        int n = 0, bad_bytes = 0;
        clean();
        q256.delete(); done256_cnt = 0; tx_ready = 1'b1;
        trig = 1'b1;
        step();
        trig = 1'b0;
        total++; if (busy256 !== 1'b0) begin bad++; $display("FAIL trig_before_arm: busy got %b want 0", busy256); end
        wr256 = 0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trig = 1'b1; sv = 1'b1; sample = 16'd0;
        step();
        trig = 1'b0;
        for (int i = 1; i < 256; i++) begin
            sv = 1'b0;
            step();
            sv = 1'b1; sample = 16'(i);
            step();
        end
        sv = 1'b0;
        while (done256_cnt == 0 && n < 1500) begin
            step();
            n++;
        end
        repeat (3) step();
        total++; if (done256_cnt != 1) begin bad++; $display("FAIL gap_done_pulses: got %0d want 1", done256_cnt); end
        total++; if (q256.size() != 512) begin bad++; $display("FAIL gap_count: got %0d want 512", q256.size()); end
        for (int i = 0; i < 256; i++) begin
            if (2 * i + 1 >= q256.size() || q256[2*i] !== 8'(i) || q256[2*i+1] !== 8'h00) bad_bytes++;
        end
        total++; if (bad_bytes != 0) begin bad++; $display("FAIL gap_data: got %0d wrong words want 0", bad_bytes); end
        total++; if (wr256 != 256) begin bad++; $display("FAIL gap_writes: got %0d want 256", wr256); end
    endtask

    task automatic test_abort();
        int n = 0, start;
        clean();
        q4.delete(); done4_cnt = 0; tx_ready = 1'b1;
        burst4(16'h1111, 16'h2222, 16'h3344, 16'h5566);
        while (q4.size() < 5 && n < 100) begin
            step();
            n++;
        end
        total++; if (v4 !== 1'b1 || d4 !== 8'h33) begin bad++; $display("FAIL abort_pre: valid=%b data=%h want 1/33", v4, d4); end
        start = done4_cnt;
        abort = 1'b1;
        step();
        abort = 1'b0;
        total++; if (v4 !== 1'b0) begin bad++; $display("FAIL abort_valid: got %b want 0", v4); end
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL abort_idle: busy got %b want 0", busy4); end
        repeat (5) step();
        total++; if (done4_cnt != start) begin bad++; $display("FAIL abort_no_done: got %0d pulses want %0d", done4_cnt, start); end
        total++; if (q4.size() != 6) begin bad++; $display("FAIL abort_count: got %0d want 6", q4.size()); end
        for (int i = 0; i < 6; i++) begin
            logic [7:0] got;
            got = i < q4.size() ? q4[i] : 8'hxx;
            total++; if (got !== exp_c[i]) begin bad++; $display("FAIL abort_byte%0d: got %h want %h", i, got, exp_c[i]); end
        end
        q4.delete();
        burst4(16'h5AA5, 16'h0F0F, 16'hC3C3, 16'h7E81);
        wait_done4(100, 1'b0);
        repeat (3) step();
        total++; if (q4.size() != 8) begin bad++; $display("FAIL rearm_count: got %0d want 8", q4.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = i < q4.size() ? q4[i] : 8'hxx;
            total++; if (got !== exp_b[i]) begin bad++; $display("FAIL rearm_byte%0d: got %h want %h", i, got, exp_b[i]); end
        end
    endtask

    task automatic test_async_reset();
        clean();
        arm = 1'b1;
        step();
        arm = 1'b0;
        trig = 1'b1; sv = 1'b1; sample = 16'hBEEF;
        step();
        trig = 1'b0; sample = 16'hCAFE;
        #2;
        rst = 1'b1;
        #1;
        total++; if (busy4 !== 1'b0 || busy256 !== 1'b0) begin bad++; $display("FAIL arst_busy: got %b/%b want 0/0", busy4, busy256); end
        total++; if (v4 !== 1'b0 || d4 !== 8'h00 || done4 !== 1'b0) begin bad++; $display("FAIL arst_outputs: valid=%b data=%h done=%b want 0/00/0", v4, d4, done4); end
        total++; if (u_dut4.cnt_q !== '0) begin bad++; $display("FAIL arst_count: got %0d want 0", u_dut4.cnt_q); end
        sv = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        arm = 1'b1;
        step();
        arm = 1'b0;
        total++; if (busy4 !== 1'b1) begin bad++; $display("FAIL arst_rearm: busy got %b want 1", busy4); end
        clean();
    endtask

    task automatic test_ignored();
        int n = 0;
        clean();
        q4.delete(); done4_cnt = 0; tx_ready = 1'b0;
        arm = 1'b1;
        step();
        arm = 1'b0;
        trig = 1'b1; sv = 1'b1; sample = 16'h1234;
        step();
        trig = 1'b0; arm = 1'b1; sample = 16'hABCD;
        step();
        arm = 1'b0; sample = 16'h0001;
        step();
        sample = 16'hFFFF;
        step();
        sv = 1'b0;
        while (!v4 && n < 10) begin
            step();
            n++;
        end
        total++; if (v4 !== 1'b1 || d4 !== 8'h34) begin bad++; $display("FAIL ign_first_lo: valid=%b data=%h want 1/34", v4, d4); end
        arm = 1'b1;
        step();
        arm = 1'b0;
        total++; if (v4 !== 1'b1 || d4 !== 8'h34) begin bad++; $display("FAIL ign_arm_send_lo: valid=%b data=%h want 1/34", v4, d4); end
        wait_done4(100, 1'b0);
        repeat (3) step();
        total++; if (q4.size() != 8) begin bad++; $display("FAIL ign_count: got %0d want 8", q4.size()); end
        for (int i = 0; i < 8; i++) begin
            logic [7:0] got;
            got = i < q4.size() ? q4[i] : 8'hxx;
            total++; if (got !== exp_a[i]) begin bad++; $display("FAIL ign_byte%0d: got %h want %h", i, got, exp_a[i]); end
        end
        total++; if (done4_cnt != 1) begin bad++; $display("FAIL ign_done_pulses: got %0d want 1", done4_cnt); end
        abort = 1'b1; arm = 1'b1;
        step();
        abort = 1'b0; arm = 1'b0;
        total++; if (busy4 !== 1'b0 || busy256 !== 1'b0) begin bad++; $display("FAIL abort_arm_idle: busy got %b/%b want 0/0", busy4, busy256); end
        step();
        total++; if (busy4 !== 1'b0) begin bad++; $display("FAIL abort_arm_stay: busy got %b want 0", busy4); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_abort();
        test_async_reset();
        test_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/x_mem_capture_ctrl.md
Name: x_mem_capture_ctrl

Overview:
- Sequencer that owns one x_mem instance (256 x 16 block RAM, registered read, 1-cycle read latency).
- Once armed and triggered, it records a burst of 16-bit delay-line samples into the RAM.
- It then drains the burst as a byte stream over a valid/ready handshake to the UART transmitter.
- It sits between the delay-line sampler and the host link, and is the only master of the RAM.

Parameters:
- DEPTH, 256, number of samples per burst; legal range 1..256.
- AW, 8, RAM address width; fixed to match x_mem.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_arm  in  1  single-cycle pulse: start a new capture; honoured only in IDLE
- i_abort  in  1  return to IDLE from any state
- i_trig  in  1  trigger; honoured only in ARMED
- i_sample_valid  in  1  i_sample is valid this cycle
- i_sample  in  16  delay-line sample
- o_tx_valid  out  1  o_tx_data is valid
- o_tx_data  out  8  byte to the host link
- i_tx_ready  in  1  sink accepts the byte on this cycle when o_tx_valid=1
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse after the last byte of a burst is accepted

Behaviour:
- Reset: async, active-high.
  - FSM goes to IDLE; waddr, raddr and the count are 0.
  - o_tx_valid=0, o_tx_data=8'h00, o_busy=0, o_done=0.
  - RAM i_wen=0, i_ren=0; RAM contents are not cleared.
- States: IDLE, ARMED, CAPTURE, RD_REQ, RD_WAIT, SEND_LO, SEND_HI.
- IDLE:
  - On i_arm, go to ARMED and clear the counters.
- ARMED:
  - On i_trig, go to CAPTURE.
  - If i_sample_valid is also high in the trigger cycle, that sample is written as sample 0 at addr 0.
- CAPTURE:
  - Each i_sample_valid cycle writes i_sample to waddr (i_wen=1) and increments waddr.
  - After the write at waddr=DEPTH-1, go to RD_REQ with raddr=0.
  - The count register is AW+1 bits wide so that DEPTH=256 terminates without wrap.
- RD_REQ: i_ren=1 at raddr for exactly one cycle, then RD_WAIT.
- RD_WAIT:
  - o_rdata is valid this cycle; capture it into a 16-bit hold register.
  - Go to SEND_LO.
  - o_rdata is never used outside this cycle, since it reads X when i_ren=0.
- SEND_LO:
  - o_tx_valid=1 with o_tx_data = hold[7:0].
  - Hold valid and data stable until i_tx_ready=1, then go to SEND_HI.
- SEND_HI:
  - o_tx_valid=1 with o_tx_data = hold[15:8].
  - On i_tx_ready:
    - if raddr=DEPTH-1, go to IDLE and pulse o_done in the cycle after acceptance;
    - otherwise increment raddr and go to RD_REQ.
- o_tx_valid is deasserted in RD_REQ and RD_WAIT: a 2-cycle gap between words, none between the LO and HI bytes.
- Byte order: little-endian, addr 0 first, 2*DEPTH bytes per burst.
- i_arm and i_trig outside their honoured states are ignored (no queuing).
- i_abort:
  - Takes priority over all other inputs.
  - Next state is IDLE; counters clear; o_tx_valid drops the next cycle, even mid-handshake.
  - o_done is not pulsed; i_wen and i_ren are 0 from the abort cycle's next edge.
- i_abort and i_arm in the same cycle in IDLE: the abort wins and the block stays IDLE.
- Reset mid-burst behaves as abort, but asynchronously.
- Internal RAM drive:
  - i_wen = (state==CAPTURE || ARMED&&i_trig) && i_sample_valid.
  - i_ren only in RD_REQ.
  - Read and write never occur in the same cycle.

Decomposition:
- Package x_mem_pkg:
  - state enum (7 states, 3 bits);
  - constants MEM_AW=8, MEM_DW=16, MEM_WORDS=256;
  - byte-select enum LO/HI.
- Sub-module: x_mem, instantiated as u_mem.
  - Compiled with SIM defined in the bench, so the behavioural model and its X-on-no-read output are exercised.
- No other sub-modules.

Test Plan:
- Basic burst, DEPTH=4: arm; trig with sample_valid; samples 16'h1234, 16'hABCD, 16'h0001, 16'hFFFF; tx_ready held at 1 -> bytes 34 12 CD AB 01 00 FF FF; o_done pulses once; o_busy falls the same cycle o_done rises.
- Backpressure, DEPTH=4, same data: i_tx_ready toggled on a random 30% duty -> identical byte sequence; o_tx_data is stable while valid&&!ready; no byte duplicated or lost.
- Gapped capture plus trigger qualification: i_trig before i_arm is ignored; after arm and trig, i_sample_valid on alternate cycles with data 0..255, DEPTH=256 -> 512 bytes matching the data, waddr wraps cleanly, exactly 256 writes.
- Abort mid-drain: abort in SEND_HI of word 2 -> o_tx_valid=0 next cycle, no o_done, state IDLE; re-arm with a new burst -> only the new data is sent.
- Async reset asserted mid-CAPTURE, not aligned to i_clk -> all outputs return to reset values immediately; after release, arm is honoured again.
- Ignored inputs: i_arm during CAPTURE and during SEND_LO is ignored, and byte count stays 2*DEPTH; i_abort together with i_arm in IDLE -> o_busy stays 0.
